ram_4x8_arbiter: RTL and testbench

RAM_4X8_ARBITER -- requirements
Module: ram_4x8_arbiter

---
 rtl/ram_4x8_arbiter.sv | 109 ++++++++++
 tb/tb_ram_4x8_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_4x8_arbiter.sv
// Two-port round-robin arbiter in front of an 8x4 RAM with registered read data.
// Clears the RAM after every reset before accepting commands.
module ram_4x8_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [2:0] addr_a,
  input  logic [2:0] addr_b,
  input  logic [3:0] wdata_a,
  input  logic [3:0] wdata_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       rvalid_a,
  output logic       rvalid_b,
  output logic [3:0] rdata_a,
  output logic [3:0] rdata_b,
  output logic       init_done,
  output logic [2:0] ram_addr,
  output logic [3:0] ram_data_in,
  output logic       ram_rw,
  input  logic [3:0] ram_data_out
);

  typedef enum logic {
    INIT,
    ARB
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       last_b;
  logic       arb;
  logic       pick_a;
  logic       pick_b;

  assign arb = (state == ARB);

  // On contention the side not granted last wins.
  always_comb begin
    pick_a = req_a & (~req_b | last_b);
    pick_b = req_b & (~req_a | ~last_b);
    gnt_a  = arb & pick_a;
    gnt_b  = arb & pick_b;
  end

  always_comb begin
    ram_addr    = 3'd0;
    ram_data_in = 4'd0;
    ram_rw      = 1'b1;
    unique case (1'b1)
      ~arb: begin
        ram_addr = cnt;
        ram_rw   = 1'b0;
      end
      gnt_a: begin
        ram_addr    = addr_a;
        ram_rw      = ~we_a;
        ram_data_in = we_a ? wdata_a : 4'd0;
      end
      gnt_b: begin
        ram_addr    = addr_b;
        ram_rw      = ~we_b;
        ram_data_in = we_b ? wdata_b : 4'd0;
      end
      default: begin
        ram_addr    = 3'd0;
        ram_data_in = 4'd0;
        ram_rw      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= 3'd0;
      last_b    <= 1'b1;
      init_done <= 1'b0;
      rvalid_a  <= 1'b0;
      rvalid_b  <= 1'b0;
    end else begin
      rvalid_a <= gnt_a & ~we_a;
      rvalid_b <= gnt_b & ~we_b;
      unique case (state)
        INIT: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state     <= ARB;
            init_done <= 1'b1;
          end
        end
        ARB: begin
          if (gnt_a)
            last_b <= 1'b0;
          else if (gnt_b)
            last_b <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  assign rdata_a = rvalid_a ? ram_data_out : 4'd0;
  assign rdata_b = rvalid_b ? ram_data_out : 4'd0;

endmodule

// File: tb/tb_ram_4x8_arbiter.sv
// Directed bench for ram_4x8_arbiter with a behavioural 8x4 RAM.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_ram_4x8_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b, we_a, we_b;
  logic [2:0] addr_a, addr_b;
  logic [3:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [3:0] rdata_a, rdata_b;
  logic       init_done;
  logic [2:0] ram_addr;
  logic [3:0] ram_data_in;
  logic       ram_rw;
  logic [3:0] ram_data_out;

  logic [3:0] mem [8];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_4x8_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b),
    .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .init_done(init_done),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_rw(ram_rw), .ram_data_out(ram_data_out)
  );

  // RAM: write when rw=0, registered read when rw=1.
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 4'hF;
    ram_data_out = 4'h0;
  end
  always @(posedge clk) begin
    if (!ram_rw) mem[ram_addr] <= ram_data_in;
    else ram_data_out <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 4'hF; wdata_b = 4'hF;
  endtask

  initial begin
    idle();
    rst_n = 0;
    next();
    next();
    to_neg();
    chk("rst_init_done", {7'd0, init_done}, 8'd0);
    chk("rst_gnt", {6'd0, gnt_a, gnt_b}, 8'd0);
    chk("rst_rvalid", {6'd0, rvalid_a, rvalid_b}, 8'd0);
    chk("rst_rdata", {rdata_a, rdata_b}, 8'h00);
    chk("rst_ram_rw", {7'd0, ram_rw}, 8'd0);
    chk("rst_ram_addr", {5'd0, ram_addr}, 8'd0);
    chk("rst_ram_din", {4'd0, ram_data_in}, 8'd0);
    next();
    rst_n = 1;

    // Clear sequence: 8 writes of 0 to addresses 0..7
    for (int k = 0; k < 8; k++) begin
      to_neg();
      chk("init_rw", {7'd0, ram_rw}, 8'd0);
      chk("init_addr", {5'd0, ram_addr}, 8'(k));
      chk("init_din", {4'd0, ram_data_in}, 8'd0);
      chk("init_done_lo", {7'd0, init_done}, 8'd0);
      next();
    end
    to_neg();
    chk("init_done_hi", {7'd0, init_done}, 8'd1);
    chk("idle_rw", {7'd0, ram_rw}, 8'd1);
    chk("idle_addr", {5'd0, ram_addr}, 8'd0);
    chk("idle_gnt", {6'd0, gnt_a, gnt_b}, 8'd0);
    next();

    // A reads every address back to back; all cleared to 0
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        req_a = 1; we_a = 0; addr_a = 3'(k);
      end else begin
        req_a = 0;
      end
      to_neg();
      if (k < 8) begin
        chk("rd_gnt_a", {6'd0, gnt_a, gnt_b}, 8'b10);
        chk("rd_addr", {5'd0, ram_addr}, 8'(k));
        chk("rd_rw", {7'd0, ram_rw}, 8'd1);
        chk("rd_din", {4'd0, ram_data_in}, 8'd0);
      end
      if (k > 0) begin
        chk("rd_rvalid", {6'd0, rvalid_a, rvalid_b}, 8'b10);
        chk("rd_rdata_a", {4'd0, rdata_a}, 8'd0);
      end
      next();
    end

    // A writes 5<=A then reads it immediately
    req_a = 1; we_a = 1; addr_a = 3'd5; wdata_a = 4'hA;
    to_neg();
    chk("wr_gnt_a", {6'd0, gnt_a, gnt_b}, 8'b10);
    chk("wr_rw", {7'd0, ram_rw}, 8'd0);
    chk("wr_addr", {5'd0, ram_addr}, 8'd5);
    chk("wr_din", {4'd0, ram_data_in}, 8'hA);
    next();
    we_a = 0; wdata_a = 4'hF;
    to_neg();
    chk("rw_gnt_a", {6'd0, gnt_a, gnt_b}, 8'b10);
    chk("wr_no_rvalid", {6'd0, rvalid_a, rvalid_b}, 8'b00);
    next();
    idle();
    to_neg();
    chk("raw_rvalid", {6'd0, rvalid_a, rvalid_b}, 8'b10);
    chk("raw_rdata_a", {4'd0, rdata_a}, 8'hA);
    chk("raw_rdata_b", {4'd0, rdata_b}, 8'h0);
    chk("raw_idle_gnt", {6'd0, gnt_a, gnt_b}, 8'b00);
    next();
    to_neg();
    chk("rvalid_one_cycle", {6'd0, rvalid_a, rvalid_b}, 8'b00);
    chk("rdata_zero", {4'd0, rdata_a}, 8'h0);
    next();

    // B alone writes 3<=6; leaves last-grant at B
    req_b = 1; we_b = 1; addr_b = 3'd3; wdata_b = 4'h6;
    to_neg();
    chk("wr_gnt_b", {6'd0, gnt_a, gnt_b}, 8'b01);
    chk("wr_b_din", {4'd0, ram_data_in}, 8'h6);
    chk("wr_b_addr", {5'd0, ram_addr}, 8'd3);
    next();

    // Contention: both read; A,B,A,B with lagging rvalids
    req_a = 1; we_a = 0; addr_a = 3'd5;
    req_b = 1; we_b = 0; addr_b = 3'd3; wdata_b = 4'hF;
    to_neg();
    chk("rr1_gnt", {6'd0, gnt_a, gnt_b}, 8'b10);
    chk("rr1_addr", {5'd0, ram_addr}, 8'd5);
    chk("rr1_rvalid", {6'd0, rvalid_a, rvalid_b}, 8'b00);
    next();
    to_neg();
    chk("rr2_gnt", {6'd0, gnt_a, gnt_b}, 8'b01);
    chk("rr2_addr", {5'd0, ram_addr}, 8'd3);
    chk("rr2_rvalid", {6'd0, rvalid_a, rvalid_b}, 8'b10);
    chk("rr2_rdata", {rdata_a, rdata_b}, 8'hA0);
    next();
    to_neg();
    chk("rr3_gnt", {6'd0, gnt_a, gnt_b}, 8'b10);
    chk("rr3_rvalid", {6'd0, rvalid_a, rvalid_b}, 8'b01);
    chk("rr3_rdata", {rdata_a, rdata_b}, 8'h06);
    next();
    to_neg();
    chk("rr4_gnt", {6'd0, gnt_a, gnt_b}, 8'b01);
    chk("rr4_rvalid", {6'd0, rvalid_a, rvalid_b}, 8'b10);
    chk("rr4_rdata", {rdata_a, rdata_b}, 8'hA0);
    next();
    idle();
    to_neg();
    chk("rr5_rvalid", {6'd0, rvalid_a, rvalid_b}, 8'b01);
    chk("rr5_rdata", {rdata_a, rdata_b}, 8'h06);
    next();

    // A reads (last-grant becomes A), then reset hits
    req_a = 1; we_a = 0; addr_a = 3'd5;
    to_neg();
    chk("pre_rst_gnt", {6'd0, gnt_a, gnt_b}, 8'b10);
    next();
    rst_n = 0;
    req_a = 1; we_a = 0; addr_a = 3'd5;
    req_b = 1; we_b = 0; addr_b = 3'd3;
    to_neg();
    chk("mid_rst_rvalid", {6'd0, rvalid_a, rvalid_b}, 8'b00);
    chk("mid_rst_rdata", {rdata_a, rdata_b}, 8'h00);
    chk("mid_rst_gnt", {6'd0, gnt_a, gnt_b}, 8'b00);
    chk("mid_rst_rw", {7'd0, ram_rw}, 8'd0);
    chk("mid_rst_done", {7'd0, init_done}, 8'd0);
    next();
    rst_n = 1;

    // Requests held through INIT are never granted
    for (int k = 0; k < 8; k++) begin
      to_neg();
      chk("init2_gnt", {6'd0, gnt_a, gnt_b}, 8'b00);
      chk("init2_addr", {5'd0, ram_addr}, 8'(k));
      chk("init2_rvalid", {6'd0, rvalid_a, rvalid_b}, 8'b00);
      next();
    end
    to_neg();
    chk("arb_first_gnt", {6'd0, gnt_a, gnt_b}, 8'b10);
    chk("arb_first_addr", {5'd0, ram_addr}, 8'd5);
    next();
    to_neg();
    chk("arb_second_gnt", {6'd0, gnt_a, gnt_b}, 8'b01);
    chk("clr_rvalid_a", {6'd0, rvalid_a, rvalid_b}, 8'b10);
    chk("clr_rdata_a", {4'd0, rdata_a}, 8'h0);
    next();
    idle();
    to_neg();
    chk("clr_rvalid_b", {6'd0, rvalid_a, rvalid_b}, 8'b01);
    chk("clr_rdata_b", {4'd0, rdata_b}, 8'h0);
    next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(negedge clk) begin
    if (gnt_a && gnt_b) begin
      errors++;
      $display("FAIL dual_grant: observed=11 expected=not 11");
    end
  end

endmodule
